// File: rtl/cache_arbiter.sv
// cache_arbiter
//   Shares one single-port cache between an instruction-fetch requester
//   (port 0) and a load/store requester (port 1). Accesses are serialised:
//   one ACCESS cycle drives the cache, reads then wait RD_LAT cycles before
//   cache_q is captured and returned to the owning port with a one-cycle
//   rvalid pulse. Writes are acknowledged with rvalid at the end of ACCESS.
//
//   Build option: define CACHE_ARB_FIXED_PRIO_EN to give port 0 fixed
//   priority on ties (port 1 may starve). Default is round-robin.
//
//   Ports
//     clk, rst            clock, async active-high reset
//     rX_valid/rX_ready   request handshake (ready is combinational)
//     rX_wr/addr/wdata    request fields
//     rX_rvalid/rX_rdata  response pulse and read data (registered)
//     cache_data/addr/wr  registered drive to the cache
//     cache_q             cache read data
//
//   state  | meaning
//   IDLE   | arbitrate, accept one request
//   ACCESS | cache driven with latched request for one cycle
//   WAIT   | read latency countdown, capture cache_q at count 1
module cache_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic              r0_wr,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic              r1_wr,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [DATA_W-1:0] cache_data,
  output logic [ADDR_W-1:0] cache_addr,
  output logic              cache_wr,
  input  logic [DATA_W-1:0] cache_q
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;

  state_t     state;
  logic       owner;   // 0 = port 0 owns the access in flight
  logic [3:0] cnt;
  logic       pick1;   // port 1 would be granted this cycle
  logic       accept;

`ifdef CACHE_ARB_FIXED_PRIO_EN
  assign pick1 = r1_valid && !r0_valid;
`else
  logic last_grant;    // 1 = port 1 was granted most recently
  assign pick1 = r1_valid && (!r0_valid || !last_grant);
`endif

  // Gated by rst so ready reads 0 while reset is held, like every other output.
  assign r0_ready = !rst && (state == IDLE) && r0_valid && !pick1;
  assign r1_ready = !rst && (state == IDLE) && pick1;
  assign accept   = r0_ready || r1_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      cnt        <= 4'd0;
`ifndef CACHE_ARB_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
      cache_addr <= '0;
      cache_data <= '0;
      cache_wr   <= 1'b0;
      r0_rvalid  <= 1'b0;
      r1_rvalid  <= 1'b0;
      r0_rdata   <= '0;
      r1_rdata   <= '0;
    end else begin
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            // cache_addr/data/wr double as the latched request.
            owner      <= pick1;
`ifndef CACHE_ARB_FIXED_PRIO_EN
            last_grant <= pick1;
`endif
            cache_addr <= pick1 ? r1_addr  : r0_addr;
            cache_data <= pick1 ? r1_wdata : r0_wdata;
            cache_wr   <= pick1 ? r1_wr    : r0_wr;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          cache_wr <= 1'b0;
          if (cache_wr) begin
            if (owner) r1_rvalid <= 1'b1;
            else       r0_rvalid <= 1'b1;
            state <= IDLE;
          end else begin
            cnt   <= 4'(RD_LAT);
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            if (owner) begin
              r1_rdata  <= cache_q;
              r1_rvalid <= 1'b1;
            end else begin
              r0_rdata  <= cache_q;
              r0_rvalid <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
